// File: rtl/irq_pkg.sv
// irq_pkg: shared widths, reset mask, request/id types and FSM states for the irq request latch
package irq_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W = $clog2(N_REQ);
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [ID_W-1:0] irq_id_t;
  localparam req_vec_t MASK_RST = 8'h00;
  typedef enum logic {IDLE, PRESENT} state_e;
endpackage

// File: rtl/irq_request_latch_if.sv
// irq_request_latch_if: valid/ready id channel from the latch (master) to the consumer (slave)
interface irq_request_latch_if;
  import irq_pkg::*;
  logic irq_valid;
  logic irq_ready;
  irq_id_t irq_id;
  modport master(output irq_valid, output irq_id, input irq_ready);
  modport slave(input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/irq_request_latch_prio_pick.sv
// irq_prio_pick: combinational highest-set-index picker with an any flag
module irq_prio_pick import irq_pkg::*; (
  input  req_vec_t vec,
  output irq_id_t  id,
  output logic     any
);
  // ascending scan so the highest set bit is the last to land
  always_comb begin
    id = '0;
    for (int i = 0; i < N_REQ; i++) id = vec[i] ? irq_id_t'(i) : id;
    any = |vec;
  end
endmodule

// File: rtl/irq_request_latch.sv
// irq_request_latch: pending/mask latch presenting the highest unmasked request id over valid/ready; IRQ_LATCH_EDGE_EN selects rising-edge capture
module irq_request_latch import irq_pkg::*; (
  input  logic                       clk,
  input  logic                       rst,
  input  req_vec_t                   req,
  input  logic                       mask_wr,
  input  req_vec_t                   mask_in,
  output req_vec_t                   pending,
  output logic                       overflow,
  irq_request_latch_if.master        bus
);
  state_e state_q, state_d;
  req_vec_t pending_q, pending_d, mask_q, mask_d, ev, clr, eligible;
  logic overflow_q, overflow_d, irq_valid_q, irq_valid_d, pick_any, hs;
  irq_id_t irq_id_q, irq_id_d, pick_id;
`ifdef IRQ_LATCH_EDGE_EN
  req_vec_t req_q, req_d;
  assign req_d = req;
  // previous request levels; zero at reset so a line already high yields one event
  always_ff @(posedge clk) req_q <= rst ? '0 : req_d;
  assign ev = req & ~req_q;
`else
  assign ev = req;
`endif
  assign hs = irq_valid_q & bus.irq_ready;
  assign clr = hs ? req_vec_t'(1) << irq_id_q : '0;
  assign eligible = pending_q & ~mask_q;
  irq_prio_pick u_pick (.vec(eligible), .id(pick_id), .any(pick_any));
  // pending, overflow and mask next values; a same-cycle event beats the handshake clear
  always_comb begin
    pending_d = (pending_q & ~clr) | ev;
    overflow_d = overflow_q | |(ev & pending_q & ~clr);
    mask_d = mask_wr ? mask_in : mask_q;
  end
  // latch a pick in IDLE and hold it untouched in PRESENT until the consumer accepts
  always_comb begin
    state_d = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d = irq_id_q;
    if (state_q == IDLE && pick_any) begin
      state_d = PRESENT;
      irq_valid_d = 1'b1;
      irq_id_d = pick_id;
    end else if (state_q == PRESENT && bus.irq_ready) begin
      state_d = IDLE;
      irq_valid_d = 1'b0;
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      mask_q <= MASK_RST;
      overflow_q <= 1'b0;
      irq_valid_q <= 1'b0;
      irq_id_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      mask_q <= mask_d;
      overflow_q <= overflow_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q <= irq_id_d;
    end
  end
  assign pending = pending_q;
  assign overflow = overflow_q;
  assign bus.irq_valid = irq_valid_q;
  assign bus.irq_id = irq_id_q;
endmodule

// File: tb/tb_irq_request_latch.sv
// tb_irq_request_latch: directed plus random stimulus checked against a bit-level behavioural model
module tb_irq_request_latch;
  import irq_pkg::*;
`ifdef IRQ_LATCH_EDGE_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = '0;
  logic mask_wr = 1'b0;
  logic [7:0] mask_in = '0;
  logic [7:0] pending;
  logic overflow;
  int compared = 0;
  int mism = 0;
  logic [7:0] m_pend = '0, m_mask = '0, m_prev = '0;
  bit m_valid = 0, m_ovf = 0;
  int m_id = 0;
  irq_request_latch_if bus ();
  irq_request_latch dut (
    .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
    .pending(pending), .overflow(overflow), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rdy, input logic mwr = 1'b0,
                      input logic [7:0] mi = 8'h00, input logic rs = 1'b0);
    bit acc, e, keep;
    int hi;
    logic [7:0] np;
    req = r;
    bus.irq_ready = rdy;
    mask_wr = mwr;
    mask_in = mi;
    rst = rs;
    if (rs) begin
      m_pend = '0; m_mask = MASK_RST; m_valid = 0; m_id = 0; m_ovf = 0; m_prev = '0;
    end else begin
      acc = m_valid && rdy;
      hi = -1;
      for (int i = 0; i < 8; i++) if (m_pend[i] && !m_mask[i]) hi = i;
      for (int i = 0; i < 8; i++) begin
        e = EDGE_MODE ? (r[i] && !m_prev[i]) : r[i];
        keep = m_pend[i] && !(acc && m_id == i);
        if (e && keep) m_ovf = 1;
        np[i] = e || keep;
      end
      if (m_valid) begin
        if (rdy) m_valid = 0;
      end else if (hi >= 0) begin
        m_valid = 1;
        m_id = hi;
      end
      m_pend = np;
      if (mwr) m_mask = mi;
      m_prev = r;
    end
    @(posedge clk);
    #1;
    chk("irq_valid", {7'b0, bus.irq_valid}, {7'b0, m_valid});
    chk("irq_id", {5'b0, bus.irq_id}, 8'(m_id));
    chk("pending", pending, m_pend);
    chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
  endtask

  initial begin
    bus.irq_ready = 1'b0;
    // reset / idle
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset_pending", pending, 8'h00);
    chk("reset_valid", {7'b0, bus.irq_valid}, 8'h00);
    // priority order 4, 3, 0
    step(8'h19, 1'b1);
    for (int i = 0; i < 7; i++) step(8'h00, 1'b1);
    chk("prio_drain", pending, 8'h00);
    // masking
    step(8'h00, 1'b1, 1'b1, 8'h80);
    step(8'h82, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b1);
    chk("mask_hold", pending, 8'h80);
    step(8'h00, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b1);
    // backpressure / stability
    step(8'h02, 1'b0);
    step(8'h00, 1'b0);
    step(8'h80, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1);
    // held line: re-pend and overflow in level mode, single grant in edge mode
    for (int i = 0; i < 8; i++) step(8'h20, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b1);
    // mid-operation reset with a non-default mask
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    step(8'h00, 1'b0, 1'b1, 8'h20);
    step(8'hA2, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("midrst_pending", pending, 8'h00);
    step(8'h20, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
    // random phase
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r, mi;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mi = 8'($urandom) & 8'($urandom);
      step(r, 1'($urandom), ($urandom_range(0, 15) == 0), mi, ($urandom_range(0, 59) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Upstream front end for the 8-to-3 priority encode stage.
- Captures 8 interrupt request lines into a pending register and applies a per-line mask.
- Selects the highest-numbered unmasked pending line (bit 7 highest) and presents its 3-bit id to a consumer over valid/ready.
- Clears the pending bit only when the consumer accepts the id.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 for this revision.
- ID_W, 3, id width, equal to $clog2(N_REQ).
- MASK_RST, 8'h00, mask register value after reset (0 = line enabled).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req  in  8  raw request lines, synchronous to clk.
- mask_wr  in  1  mask register write strobe.
- mask_in  in  8  new mask value (1 = line masked).
- irq_valid  out  1  irq_id holds a presented request.
- irq_ready  in  1  consumer accepts irq_id.
- irq_id  out  3  index of the highest unmasked pending line.
- pending  out  8  raw pending register (not masked).
- overflow  out  1  sticky flag: a new event hit a line that was already pending.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - pending = 0, irq_valid = 0, irq_id = 0, overflow = 0.
  - mask = MASK_RST, state = IDLE, req_q = 0.
  - rst takes priority over every other action.
  - Reset mid-handshake drops the presented id without delivering it.
- Event definition (default, level mode): event[i] = req[i]. A line held high re-pends every cycle after it is cleared.
- Pending set: pending[i] <= 1 at the edge following event[i].
- Pending clear: on handshake (irq_valid & irq_ready), pending[irq_id] <= 0.
  - If the same bit has an event in that cycle, set wins and the bit stays 1.
- Overflow:
  - overflow <= 1 when event[i] & pending[i] & ~(clear of bit i this cycle).
  - Sticky; cleared only by rst.
- Mask:
  - When mask_wr = 1, mask <= mask_in at the next edge.
  - Masking never clears pending bits.
- State IDLE:
  - eligible = pending & ~mask.
  - If eligible != 0: irq_id <= index of the highest set bit, irq_valid <= 1, go to PRESENT.
  - Otherwise stay in IDLE.
- State PRESENT:
  - irq_id and irq_valid are held stable regardless of mask or pending changes; no withdrawal.
  - On irq_ready: clear the pending bit, irq_valid <= 0, return to IDLE.
- Timing:
  - Latency: event at edge N, pending at N+1, irq_valid at N+2.
  - Throughput: at most one grant per 2 cycles (IDLE is mandatory between grants).
  - irq_ready is ignored while irq_valid = 0.
- Selection: purely combinational from the registered pending and mask values; irq_id is a registered output.

Optional Feature:
- Macro: IRQ_LATCH_EDGE_EN.
- Defined (edge mode):
  - Extra register req_q <= req each cycle; event[i] = req[i] & ~req_q[i] (rising edge).
  - A line held high produces exactly one event.
  - req_q resets to 0, so a line already high at reset release produces one event in the first cycle.
- Undefined: level mode as above; req_q is not instantiated.

Decomposition:
- Package irq_pkg:
  - N_REQ, ID_W, MASK_RST defaults.
  - State enum {IDLE, PRESENT}.
  - typedefs req_vec_t (logic [7:0]) and irq_id_t (logic [2:0]).
- One sub-module, irq_prio_pick:
  - Combinational; input 8-bit vector.
  - Outputs: 3-bit id (highest set index wins) and an any flag.
- The top level holds the pending, mask, overflow, req_q and FSM registers.

Test Plan:
- Reset/idle: rst = 1 for 2 cycles, req = 0 → irq_valid = 0, pending = 8'h00, overflow = 0, irq_id = 3'b000.
- Priority: one-cycle pulse req = 8'h19, irq_ready = 1 → ids presented in order 4, 3, 0, each irq_valid for 1 cycle, 2 cycles apart; first irq_valid at 2 cycles after the pulse; pending ends 8'h00.
- Masking: mask_in = 8'h80 with mask_wr, then req = 8'h82 pulse → id 1 presented; pending stays 8'h80; writing mask 8'h00 → id 7 presented.
- Backpressure/stability: req = 8'h02 pulse, irq_ready = 0 for 5 cycles, then a req = 8'h80 pulse → irq_id stays 1 until irq_ready; afterwards id 7 presented.
- Overflow and set-wins:
  - Level mode, req[5] held high with irq_ready = 1 → overflow = 1; pending[5] remains 1 after each handshake.
  - Edge mode (IRQ_LATCH_EDGE_EN), same stimulus → exactly one grant of id 5, overflow = 0.
- Mid-operation reset: rst asserted while irq_valid = 1 and pending = 8'hA2 → next cycle irq_valid = 0, pending = 0, mask = MASK_RST.
